// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan decoder.
//   - Active-low segment patterns (a..g, bit6 = a) for the glyph set.
//   - Glyph codes for blank and unrecognised patterns.
//   - One-hot-low anode selects A0..A7.
//   - Scan-cycle classification of the anode bus.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_I     = 7'b1101111;
    localparam logic [6:0] SEG_N     = 7'b1101010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [4:0] GLYPH_BLANK   = 5'd16;
    localparam logic [4:0] GLYPH_UNKNOWN = 5'd31;

    localparam logic [7:0] A0 = 8'hFE;
    localparam logic [7:0] A1 = 8'hFD;
    localparam logic [7:0] A2 = 8'hFB;
    localparam logic [7:0] A3 = 8'hF7;
    localparam logic [7:0] A4 = 8'hEF;
    localparam logic [7:0] A5 = 8'hDF;
    localparam logic [7:0] A6 = 8'hBF;
    localparam logic [7:0] A7 = 8'h7F;

    typedef enum logic [1:0] {
        SCAN_BLANK,
        SCAN_STROBE,
        SCAN_ILLEGAL
    } scan_kind_e;

    // No zero bit = blanked, exactly one = legal digit strobe, more = illegal.
    function automatic scan_kind_e scan_classify(input logic [7:0] an_n);
        logic [7:0] sel;
        sel = ~an_n;
        if (sel == 8'd0)
            return SCAN_BLANK;
        else if ((sel & (sel - 8'd1)) == 8'd0)
            return SCAN_STROBE;
        else
            return SCAN_ILLEGAL;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: combinational active-low a..g pattern -> 5-bit glyph code.
//   pat   in  7  segment pattern, bit6 = a .. bit0 = g, active low
//   glyph out 5  0..15 for digits/letters, 16 blank, 31 unknown
// Letter O shares the 0 pattern and therefore decodes as 0.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [4:0] glyph
);

    always_comb begin
        glyph = GLYPH_UNKNOWN;
        case (pat)
            SEG_0:     glyph = 5'd0;
            SEG_1:     glyph = 5'd1;
            SEG_2:     glyph = 5'd2;
            SEG_3:     glyph = 5'd3;
            SEG_4:     glyph = 5'd4;
            SEG_5:     glyph = 5'd5;
            SEG_6:     glyph = 5'd6;
            SEG_7:     glyph = 5'd7;
            SEG_8:     glyph = 5'd8;
            SEG_9:     glyph = 5'd9;
            SEG_H:     glyph = 5'd10;
            SEG_E:     glyph = 5'd11;
            SEG_L:     glyph = 5'd12;
            SEG_F:     glyph = 5'd13;
            SEG_I:     glyph = 5'd14;
            SEG_N:     glyph = 5'd15;
            SEG_BLANK: glyph = GLYPH_BLANK;
            default:   glyph = GLYPH_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment scan bus, rebuilds the
// per-slot glyphs and the 5-bit timer value {half, units} from slots 5/6/7.
//   clock, reset           system clock, synchronous active-high reset
//   seq[7:0], an[7:0]      active-low segment bus (dp = bit0) and digit select
//   rd_slot/rd_glyph       registered glyph readback, 1-cycle latency
//   val/val_valid          last frame's value and whether it decoded legally
//   frame_strobe           one pulse per completed frame
//   dp_mask                latched dp per slot (1 = lit)
//   display_off            bus blanked for TIMEOUT cycles or more
//   protocol_error         pulse on a multi-zero anode pattern
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter logic [7:0] SLOT_MASK = 8'b1110_0000,
    parameter int          TIMEOUT   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seq,
    input  logic [7:0] an,
    input  logic [2:0] rd_slot,
    output logic [4:0] rd_glyph,
    output logic [4:0] val,
    output logic       val_valid,
    output logic       frame_strobe,
    output logic [7:0] dp_mask,
    output logic       display_off,
    output logic       protocol_error
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0]      seq_s1_q, seq_s1_d, an_s1_q, an_s1_d;
    logic [7:0][7:0] slot_q, slot_d;
    logic [7:0]      seen_q, seen_d, dp_mask_q, dp_mask_d;
    logic [7:0]      idle_q, idle_d;
    logic            display_off_q, display_off_d;
    logic            perr_q, perr_d;
    logic            pend_q, pend_d;       // frame completed, value rebuild due next edge
    logic            frame_strobe_q, frame_strobe_d;
    logic [4:0]      val_q, val_d, rd_glyph_q, rd_glyph_d;
    logic            val_valid_q, val_valid_d;

    logic [4:0] glyph_rd, glyph_5, glyph_6, glyph_7;

    seg_glyph_decode u_dec_rd (.pat(slot_q[rd_slot][7:1]), .glyph(glyph_rd));
    seg_glyph_decode u_dec_5  (.pat(slot_q[5][7:1]),       .glyph(glyph_5));
    seg_glyph_decode u_dec_6  (.pat(slot_q[6][7:1]),       .glyph(glyph_6));
    seg_glyph_decode u_dec_7  (.pat(slot_q[7][7:1]),       .glyph(glyph_7));

    // Value rebuild from the current slot contents.
    logic [3:0] hi, lo;
    logic       hi_ok, lo_ok, half, half_ok, rebuild_ok;
    logic [6:0] units;

    always_comb begin
        hi_ok = 1'b1;
        hi    = 4'd0;
        if (glyph_5 == GLYPH_BLANK)
            hi = 4'd0;                       // blank tens digit reads as 0
        else if (glyph_5 >= 5'd1 && glyph_5 <= 5'd9)
            hi = glyph_5[3:0];
        else
            hi_ok = 1'b0;

        lo_ok = (glyph_6 <= 5'd9);
        lo    = glyph_6[3:0];

        half_ok = (glyph_7 == 5'd0) || (glyph_7 == 5'd5);
        half    = (glyph_7 == 5'd5);

        units      = {3'b000, hi} * 7'd10 + {3'b000, lo};
        rebuild_ok = hi_ok && lo_ok && half_ok && (units <= 7'd15);
    end

    scan_kind_e kind;
    logic [7:0] strobe_bit;

    always_comb begin
        seq_s1_d       = seq;
        an_s1_d        = an;
        slot_d         = slot_q;
        seen_d         = seen_q;
        dp_mask_d      = dp_mask_q;
        idle_d         = idle_q;
        display_off_d  = display_off_q;
        perr_d         = 1'b0;
        pend_d         = 1'b0;
        frame_strobe_d = 1'b0;
        val_d          = val_q;
        val_valid_d    = val_valid_q;
        rd_glyph_d     = glyph_rd;

        kind       = scan_classify(an_s1_q);
        strobe_bit = ~an_s1_q;

        // Slots now hold the completing write; publish the frame.
        if (pend_q) begin
            frame_strobe_d = 1'b1;
            val_valid_d    = rebuild_ok;
            if (rebuild_ok)
                val_d = {half, units[3:0]};
        end

        case (kind)
            SCAN_STROBE: begin
                for (int i = 0; i < 8; i++) begin
                    if (strobe_bit[i]) begin
                        slot_d[i]    = seq_s1_q;
                        dp_mask_d[i] = ~seq_s1_q[0];
                    end
                end
                idle_d        = 8'd0;
                display_off_d = 1'b0;
                // The completing strobe does not count toward the next frame.
                if (((seen_q | strobe_bit) & SLOT_MASK) == SLOT_MASK) begin
                    seen_d = 8'd0;
                    pend_d = 1'b1;
                end else begin
                    seen_d = seen_q | strobe_bit;
                end
            end
            SCAN_BLANK: begin
                if (idle_q != TIMEOUT_C)
                    idle_d = idle_q + 8'd1;
                if (idle_d == TIMEOUT_C) begin
                    display_off_d = 1'b1;
                    seen_d        = 8'd0;
                    val_valid_d   = 1'b0;
                end
            end
            default: perr_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seq_s1_q       <= 8'hFF;
            an_s1_q        <= 8'hFF;
            slot_q         <= {8{8'hFF}};
            seen_q         <= 8'd0;
            dp_mask_q      <= 8'd0;
            idle_q         <= 8'd0;
            display_off_q  <= 1'b1;
            perr_q         <= 1'b0;
            pend_q         <= 1'b0;
            frame_strobe_q <= 1'b0;
            val_q          <= 5'd0;
            val_valid_q    <= 1'b0;
            rd_glyph_q     <= GLYPH_BLANK;
        end else begin
            seq_s1_q       <= seq_s1_d;
            an_s1_q        <= an_s1_d;
            slot_q         <= slot_d;
            seen_q         <= seen_d;
            dp_mask_q      <= dp_mask_d;
            idle_q         <= idle_d;
            display_off_q  <= display_off_d;
            perr_q         <= perr_d;
            pend_q         <= pend_d;
            frame_strobe_q <= frame_strobe_d;
            val_q          <= val_d;
            val_valid_q    <= val_valid_d;
            rd_glyph_q     <= rd_glyph_d;
        end
    end

    assign rd_glyph       = rd_glyph_q;
    assign val            = val_q;
    assign val_valid      = val_valid_q;
    assign frame_strobe   = frame_strobe_q;
    assign dp_mask        = dp_mask_q;
    assign display_off    = display_off_q;
    assign protocol_error = perr_q;

endmodule
